// File: rtl/multicore_control_regs_pkg.sv
// Shared definitions for the multicore start/finish controller: register map,
// STATUS field layout helpers and decoded write-strobe bundle.
package multicore_control_regs_pkg;

    localparam logic [1:0] REG_START  = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_CYCLES = 2'd3;

    // STATUS layout: {err, done[N-1:0], busy[N-1:0]}
    function automatic int unsigned status_done_lsb(input int unsigned num_cores);
        return num_cores;
    endfunction

    function automatic int unsigned status_err_bit(input int unsigned num_cores);
        return 2 * num_cores;
    endfunction

    typedef struct packed {
        logic start;
        logic status;
        logic irq_en;
    } wr_sel_t;

endpackage

// File: rtl/multicore_control_regs_if.sv
// Host slave bus of the multicore controller: register select, strobes,
// write/read data and the level interrupt back to the host.
interface multicore_control_regs_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 2
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [WIDTH-1:0]  data_write;
    logic [WIDTH-1:0]  data_read;
    logic              irq;

    modport master (
        output address,
        output read,
        output write,
        output data_write,
        input  data_read,
        input  irq
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  data_write,
        output data_read,
        output irq
    );
endinterface

// File: rtl/multicore_control_regs_core_channel_ctrl.sv
// Per-core channel: busy/done state, one-cycle start pulse and the protocol
// error contribution (start while busy, finish while idle).
module multicore_control_regs_core_channel_ctrl (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_req_i,
    input  logic finish_i,
    input  logic done_clr_i,
    output logic start_pulse_o,
    output logic busy_o,
    output logic busy_next_o,
    output logic done_o,
    output logic start_ok_o,
    output logic err_o
);
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic pulse_q, pulse_d;
    logic start_ok, finish_ok;

    always_comb begin
        start_ok  = start_req_i & ~busy_q;
        finish_ok = finish_i & busy_q;
        busy_d    = busy_q;
        done_d    = done_q;
        if (done_clr_i) begin
            done_d = 1'b0;
        end
        if (start_ok) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end
        // Applied last so a finish beats both a same-cycle W1C and a start.
        if (finish_ok) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        pulse_d = start_ok;
        err_o   = (start_req_i & busy_q) | (finish_i & ~busy_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

    assign start_pulse_o = pulse_q;
    assign busy_o        = busy_q;
    assign busy_next_o   = busy_d;
    assign done_o        = done_q;
    assign start_ok_o    = start_ok;
endmodule

// File: rtl/multicore_control_regs.sv
// Memory-mapped start/finish controller for NUM_CORES cores: register decode,
// read mux, maskable level IRQ and a saturating frame cycle counter.
module multicore_control_regs
    import multicore_control_regs_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset_sink_reset,
    multicore_control_regs_if.slave    bus,
    input  logic [NUM_CORES-1:0]       interrupt_finish,
    output logic [NUM_CORES-1:0]       interrupt_start
);
    localparam int unsigned DoneLsb = status_done_lsb(NUM_CORES);
    localparam int unsigned ErrBit  = status_err_bit(NUM_CORES);

    wr_sel_t              wr_sel;
    logic [NUM_CORES-1:0] start_req, done_clr;
    logic [NUM_CORES-1:0] busy, busy_next, done, start_ok, chan_err;
    logic [WIDTH-1:0]     status_word;

    logic                 err_q, err_d;
    logic [NUM_CORES-1:0] irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;
    logic                 timing_q, timing_d;
    logic [WIDTH-1:0]     cycles_q, cycles_d;
    logic [WIDTH-1:0]     data_read_q, data_read_d;
    logic                 unused_wdata;

    assign unused_wdata = ^bus.data_write;

    always_comb begin
        wr_sel = '0;
        if (bus.write) begin
            wr_sel.start  = (bus.address == ADDR_W'(REG_START));
            wr_sel.status = (bus.address == ADDR_W'(REG_STATUS));
            wr_sel.irq_en = (bus.address == ADDR_W'(REG_IRQ_EN));
        end
        start_req = wr_sel.start  ? bus.data_write[NUM_CORES-1:0] : '0;
        done_clr  = wr_sel.status ? bus.data_write[DoneLsb +: NUM_CORES] : '0;
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        multicore_control_regs_core_channel_ctrl u_chan (
            .clk_i         (clk),
            .rst_i         (reset_sink_reset),
            .start_req_i   (start_req[i]),
            .finish_i      (interrupt_finish[i]),
            .done_clr_i    (done_clr[i]),
            .start_pulse_o (interrupt_start[i]),
            .busy_o        (busy[i]),
            .busy_next_o   (busy_next[i]),
            .done_o        (done[i]),
            .start_ok_o    (start_ok[i]),
            .err_o         (chan_err[i])
        );
    end

    always_comb begin
        err_d = err_q;
        if (|chan_err) begin
            err_d = 1'b1;
        end else if (wr_sel.status && bus.data_write[ErrBit]) begin
            err_d = 1'b0;
        end

        irq_en_d = wr_sel.irq_en ? bus.data_write[NUM_CORES-1:0] : irq_en_q;
        irq_d    = |(done & irq_en_q);

        // A frame opens on the first accepted start and closes once every core is idle.
        timing_d = timing_q;
        cycles_d = cycles_q;
        if (timing_q) begin
            cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + WIDTH'(1);
            timing_d = |busy_next;
        end else if (|start_ok) begin
            cycles_d = '0;
            timing_d = 1'b1;
        end

        status_word                         = '0;
        status_word[NUM_CORES-1:0]          = busy;
        status_word[DoneLsb +: NUM_CORES]   = done;
        status_word[ErrBit]                 = err_q;

        data_read_d = data_read_q;
        if (bus.read) begin
            data_read_d = '0;
            if (bus.address == ADDR_W'(REG_STATUS)) begin
                data_read_d = status_word;
            end else if (bus.address == ADDR_W'(REG_IRQ_EN)) begin
                data_read_d[NUM_CORES-1:0] = irq_en_q;
            end else if (bus.address == ADDR_W'(REG_CYCLES)) begin
                data_read_d = cycles_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            err_q       <= 1'b0;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
            timing_q    <= 1'b0;
            cycles_q    <= '0;
            data_read_q <= '0;
        end else begin
            err_q       <= err_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            timing_q    <= timing_d;
            cycles_q    <= cycles_d;
            data_read_q <= data_read_d;
        end
    end

    assign bus.data_read = data_read_q;
    assign bus.irq       = irq_q;
endmodule

// File: tb/tb_multicore_control_regs.sv
// Directed bench: a 4-core/32-bit instance for the register protocol and a
// 1-core/3-bit instance so the frame counter can be driven into saturation.
module tb_multicore_control_regs;
    import multicore_control_regs_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] fin;
    logic [3:0] st;
    logic [0:0] s_fin;
    logic [0:0] s_st;
    int         checks;
    int         failures;

    multicore_control_regs_if #(.WIDTH(32), .ADDR_W(2)) m_if ();
    multicore_control_regs_if #(.WIDTH(3),  .ADDR_W(2)) s_if ();

    multicore_control_regs #(.WIDTH(32), .NUM_CORES(4), .ADDR_W(2)) u_dut (
        .clk              (clk),
        .reset_sink_reset (rst),
        .bus              (m_if),
        .interrupt_finish (fin),
        .interrupt_start  (st)
    );

    multicore_control_regs #(.WIDTH(3), .NUM_CORES(1), .ADDR_W(2)) u_small (
        .clk              (clk),
        .reset_sink_reset (rst),
        .bus              (s_if),
        .interrupt_finish (s_fin),
        .interrupt_start  (s_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic m_write(input logic [1:0] a, input logic [31:0] d);
        m_if.address    = a;
        m_if.data_write = d;
        m_if.write      = 1'b1;
        step();
        m_if.write      = 1'b0;
        m_if.data_write = '0;
    endtask

    task automatic m_read(input logic [1:0] a);
        m_if.address = a;
        m_if.read    = 1'b1;
        step();
        m_if.read    = 1'b0;
    endtask

    task automatic s_write(input logic [1:0] a, input logic [2:0] d);
        s_if.address    = a;
        s_if.data_write = d;
        s_if.write      = 1'b1;
        step();
        s_if.write      = 1'b0;
        s_if.data_write = '0;
    endtask

    task automatic s_read(input logic [1:0] a);
        s_if.address = a;
        s_if.read    = 1'b1;
        step();
        s_if.read    = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        fin      = '0;
        s_fin    = '0;
        m_if.address = '0; m_if.read = 1'b0; m_if.write = 1'b0; m_if.data_write = '0;
        s_if.address = '0; s_if.read = 1'b0; s_if.write = 1'b0; s_if.data_write = '0;
        repeat (3) step();
        rst = 1'b0;

        chk("reset_start", 32'(st), 32'h0);
        chk("reset_irq", 32'(m_if.irq), 32'h0);
        chk("reset_rdata", m_if.data_read, 32'h0);
        chk("small_reset_rdata", 32'(s_if.data_read), 32'h0);
        m_read(REG_STATUS);
        chk("reset_status", m_if.data_read, 32'h0);

        // Start cores 0 and 2; finish 0 two edges later and 2 ten edges after that.
        m_write(REG_START, 32'h5);
        chk("start_pulse", 32'(st), 32'h5);
        step();
        chk("start_pulse_one_cycle", 32'(st), 32'h0);
        m_if.address = REG_STATUS;
        m_if.read    = 1'b1;
        fin          = 4'b0001;
        step();
        m_if.read    = 1'b0;
        fin          = '0;
        chk("status_busy", m_if.data_read, 32'h5);
        repeat (9) step();
        fin = 4'b0100;
        step();
        fin = '0;
        m_read(REG_CYCLES);
        chk("frame_cycles", m_if.data_read, 32'd12);
        m_read(REG_STATUS);
        chk("status_done", m_if.data_read, 32'h50);
        chk("irq_masked", 32'(m_if.irq), 32'h0);
        repeat (3) step();
        m_read(REG_CYCLES);
        chk("cycles_frozen", m_if.data_read, 32'd12);

        // IRQ enable, then W1C of done[0].
        m_write(REG_IRQ_EN, 32'h1);
        chk("irq_lag", 32'(m_if.irq), 32'h0);
        step();
        chk("irq_set", 32'(m_if.irq), 32'h1);
        m_read(REG_IRQ_EN);
        chk("irq_en_read", m_if.data_read, 32'h1);
        m_write(REG_STATUS, 32'h10);
        chk("irq_hold_after_w1c", 32'(m_if.irq), 32'h1);
        step();
        chk("irq_clear", 32'(m_if.irq), 32'h0);
        m_read(REG_STATUS);
        chk("status_after_w1c", m_if.data_read, 32'h40);

        // Start on a busy core is rejected and flags err.
        m_write(REG_START, 32'h2);
        chk("start_core1", 32'(st), 32'h2);
        m_write(REG_START, 32'h2);
        chk("start_busy_no_pulse", 32'(st), 32'h0);
        m_read(REG_STATUS);
        chk("status_err", m_if.data_read, 32'h142);
        m_write(REG_STATUS, 32'h100);
        m_read(REG_STATUS);
        chk("status_err_w1c", m_if.data_read, 32'h042);

        // Same-cycle W1C of done[3] and finish[3]: set wins.
        m_write(REG_START, 32'h8);
        chk("start_core3", 32'(st), 32'h8);
        m_if.address    = REG_STATUS;
        m_if.data_write = 32'h80;
        m_if.write      = 1'b1;
        fin             = 4'b1000;
        step();
        m_if.write      = 1'b0;
        m_if.data_write = '0;
        fin             = '0;
        m_read(REG_STATUS);
        chk("done_set_wins", m_if.data_read, 32'h0C2);
        fin = 4'b1000;
        step();
        fin = '0;
        m_read(REG_STATUS);
        chk("finish_idle_err", m_if.data_read, 32'h1C2);

        // Same-cycle read and write return the pre-write value.
        m_if.address    = REG_STATUS;
        m_if.data_write = 32'h100;
        m_if.read       = 1'b1;
        m_if.write      = 1'b1;
        step();
        m_if.read       = 1'b0;
        m_if.write      = 1'b0;
        m_if.data_write = '0;
        chk("rw_pre_write", m_if.data_read, 32'h1C2);
        m_read(REG_STATUS);
        chk("rw_post_write", m_if.data_read, 32'h0C2);

        m_write(REG_START, 32'hF0);
        chk("start_high_bits_no_pulse", 32'(st), 32'h0);
        m_read(REG_STATUS);
        chk("start_high_bits_no_err", m_if.data_read, 32'h0C2);

        // Reset mid-frame with a start pending on the same edge.
        m_write(REG_IRQ_EN, 32'hC);
        step();
        chk("irq_before_reset", 32'(m_if.irq), 32'h1);
        m_if.address    = REG_START;
        m_if.data_write = 32'h1;
        m_if.write      = 1'b1;
        rst             = 1'b1;
        step();
        m_if.write      = 1'b0;
        m_if.data_write = '0;
        chk("reset_no_pulse", 32'(st), 32'h0);
        chk("reset_irq_mid", 32'(m_if.irq), 32'h0);
        chk("reset_rdata_mid", m_if.data_read, 32'h0);
        rst = 1'b0;
        m_read(REG_STATUS);
        chk("reset_status_mid", m_if.data_read, 32'h0);
        m_read(REG_CYCLES);
        chk("reset_cycles_mid", m_if.data_read, 32'h0);
        m_read(REG_IRQ_EN);
        chk("reset_irq_en_mid", m_if.data_read, 32'h0);

        // 3-bit counter saturates at 7.
        s_write(REG_START, 3'h1);
        chk("small_start", 32'(s_st), 32'h1);
        repeat (10) step();
        s_read(REG_CYCLES);
        chk("small_cycles_sat", 32'(s_if.data_read), 32'h7);
        s_fin = 1'b1;
        step();
        s_fin = 1'b0;
        s_read(REG_STATUS);
        chk("small_status_done", 32'(s_if.data_read), 32'h2);
        s_read(REG_CYCLES);
        chk("small_cycles_hold", 32'(s_if.data_read), 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
